// File: rtl/axil_cmd_initiator.sv
// AXI4-Lite single-beat initiator: turns one cmd_* request into one AXI-Lite read or write,
// returns data/status on rsp_*, aborts on a per-transaction timeout and drains stray beats in IDLE.
module axil_cmd_initiator #(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [2:0] AXI_PROT       = 3'b000
) (
  input  logic        axilClk,
  input  logic        axilRstN,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic [7:0]  stray_cnt,
  output logic [31:0] axilReadMaster_araddr,
  output logic [2:0]  axilReadMaster_arprot,
  output logic        axilReadMaster_arvalid,
  output logic        axilReadMaster_rready,
  input  logic        axilReadSlave_arready,
  input  logic [31:0] axilReadSlave_rdata,
  input  logic [1:0]  axilReadSlave_rresp,
  input  logic        axilReadSlave_rvalid,
  output logic [31:0] axilWriteMaster_awaddr,
  output logic [2:0]  axilWriteMaster_awprot,
  output logic        axilWriteMaster_awvalid,
  output logic [31:0] axilWriteMaster_wdata,
  output logic [3:0]  axilWriteMaster_wstrb,
  output logic        axilWriteMaster_wvalid,
  output logic        axilWriteMaster_bready,
  input  logic        axilWriteSlave_awready,
  input  logic        axilWriteSlave_wready,
  input  logic [1:0]  axilWriteSlave_bresp,
  input  logic        axilWriteSlave_bvalid
);

  localparam bit TMO_ON = (TIMEOUT_CYCLES != 0);
  localparam int TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP} state_t;

  state_t          state;
  logic [31:0]     addr_q;
  logic [TW-1:0]   tmo_cnt;
  logic            progress, active, abort;
  logic [8:0]      stray_sum;

  assign axilReadMaster_araddr  = addr_q;
  assign axilWriteMaster_awaddr = addr_q;
  assign axilReadMaster_arprot  = AXI_PROT;
  assign axilWriteMaster_awprot = AXI_PROT;

  // "progress" = the current state leaves normally this cycle; it beats an expiring timer
  always_comb begin
    progress = 1'b0;
    case (state)
      WR_REQ:  progress = (!axilWriteMaster_awvalid || axilWriteSlave_awready) &&
                          (!axilWriteMaster_wvalid  || axilWriteSlave_wready);
      WR_RESP: progress = axilWriteSlave_bvalid;
      RD_REQ:  progress = axilReadSlave_arready;
      RD_DATA: progress = axilReadSlave_rvalid;
      default: progress = 1'b0;
    endcase
  end

  assign active = (state == WR_REQ) || (state == WR_RESP) || (state == RD_REQ) || (state == RD_DATA);
  // Expiry fires on the TIMEOUT_CYCLES-th cycle after entry, so a valid is high for exactly that many cycles
  assign abort  = TMO_ON && active && !progress && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign stray_sum = {1'b0, stray_cnt} + 9'(axilReadSlave_rvalid) + 9'(axilWriteSlave_bvalid);

  always_ff @(posedge axilClk or negedge axilRstN) begin
    if (!axilRstN) begin
      state                   <= IDLE;
      cmd_ready               <= 1'b1;
      addr_q                  <= '0;
      axilWriteMaster_wdata   <= '0;
      axilWriteMaster_wstrb   <= '0;
      axilWriteMaster_awvalid <= 1'b0;
      axilWriteMaster_wvalid  <= 1'b0;
      axilWriteMaster_bready  <= 1'b1;
      axilReadMaster_arvalid  <= 1'b0;
      axilReadMaster_rready   <= 1'b1;
      rsp_valid               <= 1'b0;
      rsp_rdata               <= '0;
      rsp_resp                <= '0;
      rsp_timeout             <= 1'b0;
      stray_cnt               <= '0;
      tmo_cnt                 <= '0;
    end else begin
      if (TMO_ON && active) tmo_cnt <= tmo_cnt + 1'b1;
      case (state)
        IDLE: begin
          // Readies are held high here, so any beat seen is unsolicited
          stray_cnt <= stray_sum[8] ? 8'hFF : stray_sum[7:0];
          if (cmd_valid) begin
            addr_q                 <= cmd_addr & ~32'h3;
            axilWriteMaster_wdata  <= cmd_wdata;
            axilWriteMaster_wstrb  <= cmd_wstrb;
            cmd_ready              <= 1'b0;
            axilReadMaster_rready  <= 1'b0;
            axilWriteMaster_bready <= 1'b0;
            tmo_cnt                <= '0;
            if (cmd_write) begin
              axilWriteMaster_awvalid <= 1'b1;
              axilWriteMaster_wvalid  <= 1'b1;
              state                   <= WR_REQ;
            end else begin
              axilReadMaster_arvalid <= 1'b1;
              state                  <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (axilWriteSlave_awready) axilWriteMaster_awvalid <= 1'b0;
          if (axilWriteSlave_wready)  axilWriteMaster_wvalid  <= 1'b0;
          if (progress) begin
            axilWriteMaster_bready <= 1'b1;
            state                  <= WR_RESP;
          end
        end
        WR_RESP: if (progress) begin
          axilWriteMaster_bready <= 1'b0;
          rsp_valid              <= 1'b1;
          rsp_resp               <= axilWriteSlave_bresp;
          rsp_rdata              <= '0;
          rsp_timeout            <= 1'b0;
          state                  <= RESP;
        end
        RD_REQ: if (progress) begin
          axilReadMaster_arvalid <= 1'b0;
          axilReadMaster_rready  <= 1'b1;
          state                  <= RD_DATA;
        end
        RD_DATA: if (progress) begin
          axilReadMaster_rready <= 1'b0;
          rsp_valid             <= 1'b1;
          rsp_resp              <= axilReadSlave_rresp;
          rsp_rdata             <= axilReadSlave_rdata;
          rsp_timeout           <= 1'b0;
          state                 <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid              <= 1'b0;
          cmd_ready              <= 1'b1;
          axilReadMaster_rready  <= 1'b1;
          axilWriteMaster_bready <= 1'b1;
          state                  <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (abort) begin
        axilWriteMaster_awvalid <= 1'b0;
        axilWriteMaster_wvalid  <= 1'b0;
        axilWriteMaster_bready  <= 1'b0;
        axilReadMaster_arvalid  <= 1'b0;
        axilReadMaster_rready   <= 1'b0;
        rsp_valid               <= 1'b1;
        rsp_resp                <= 2'b10;
        rsp_rdata               <= '0;
        rsp_timeout             <= 1'b1;
        state                   <= RESP;
      end
    end
  end

endmodule
